// File: rtl/cu_pkg.sv
// Shared opcode, ALU-function and state definitions for the sequencer control unit.
package cu_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  function automatic logic [1:0] alu_of(input logic [2:0] op);
    case (op)
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      OP_OR:   alu_of = ALU_OR;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; all-zero output when disabled.
module onehot_dec #(
  parameter int NREGS = 8
) (
  input  logic [$clog2(NREGS)-1:0] idx_i,
  input  logic                     en_i,
  output logic [NREGS-1:0]         onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control sequencer: latches an instruction in IDLE and steps T1..T3,
// decoding datapath selects/enables from state and IR only.
module seq_control_unit
  import cu_pkg::*;
#(
  parameter  int NREGS = 8,
  localparam int RW    = $clog2(NREGS),
  localparam int IW    = 3 + 2 * RW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             stall,
  input  logic [IW-1:0]    instr,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [1:0]       alu_op,
  output logic             imm_sel,
  output logic             g_sel,
  output logic [NREGS-1:0] reg_sel,
  output logic [NREGS-1:0] reg_en,
  output logic             a_en,
  output logic             g_en,
  output logic [15:0]      retired,
  output state_t           dbg_state
);

  // Handshake: an instruction transfers on any rising edge where ready=1 and run=1;
  // run is ignored at every other edge and instr is only sampled at that edge.

  state_t          state_q, state_d;
  logic [IW-1:0]   ir_q;
  logic [15:0]     retired_q;

  logic [2:0]      op;
  logic [RW-1:0]   rx, ry;
  logic            is_alu;

  logic [RW-1:0]   sel_idx;
  logic            sel_en;
  logic            wr_raw, a_raw, g_raw, done_raw, err_raw;

  assign op     = ir_q[IW-1 -: 3];
  assign rx     = ir_q[2*RW-1 -: RW];
  assign ry     = ir_q[RW-1:0];
  assign is_alu = (op >= OP_ADD) && (op <= OP_OR);

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    imm_sel  = 1'b0;
    g_sel    = 1'b0;
    alu_op   = ALU_ADD;
    sel_idx  = ry;
    sel_en   = 1'b0;
    wr_raw   = 1'b0;
    a_raw    = 1'b0;
    g_raw    = 1'b0;
    done_raw = 1'b0;
    err_raw  = 1'b0;
    case (state_q)
      S_IDLE: ready = 1'b1;
      S_T1: begin
        if (op == OP_MV) begin
          sel_en   = 1'b1;
          wr_raw   = 1'b1;
          done_raw = 1'b1;
          state_d  = S_IDLE;
        end else if (op == OP_MVI) begin
          imm_sel  = 1'b1;
          wr_raw   = 1'b1;
          done_raw = 1'b1;
          state_d  = S_IDLE;
        end else if (is_alu) begin
          sel_idx  = rx;
          sel_en   = 1'b1;
          a_raw    = 1'b1;
          state_d  = S_T2;
        end else begin
          err_raw  = 1'b1;
          done_raw = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_T2: begin
        sel_en  = 1'b1;
        g_raw   = 1'b1;
        alu_op  = alu_of(op);
        state_d = S_T3;
      end
      S_T3: begin
        g_sel    = 1'b1;
        wr_raw   = 1'b1;
        done_raw = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall suppresses every side effect but leaves the bus selects visible.
  assign a_en = a_raw    & ~stall;
  assign g_en = g_raw    & ~stall;
  assign done = done_raw & ~stall;
  assign err  = err_raw  & ~stall;

  onehot_dec #(.NREGS(NREGS)) u_sel_dec (
    .idx_i    (sel_idx),
    .en_i     (sel_en),
    .onehot_o (reg_sel)
  );

  onehot_dec #(.NREGS(NREGS)) u_wr_dec (
    .idx_i    (rx),
    .en_i     (wr_raw & ~stall),
    .onehot_o (reg_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        if (run) begin
          ir_q    <= instr;
          state_q <= S_T1;
        end
      end else if (!stall) begin
        state_q <= state_d;
      end
      if (done && !err) retired_q <= retired_q + 16'd1;
    end
  end

  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: NREGS=8 instance for most scenarios, NREGS=4 for the narrow build.
module tb_seq_control_unit;
  import cu_pkg::*;

  logic        clk;
  logic        reset;
  logic        run, stall;
  logic [8:0]  instr;
  logic        ready, done, err, imm_sel, g_sel, a_en, g_en;
  logic [1:0]  alu_op;
  logic [7:0]  reg_sel, reg_en;
  logic [15:0] retired;
  state_t      dbg_state;

  logic        run4;
  logic [6:0]  instr4;
  logic        ready4, done4, err4, imm_sel4, g_sel4, a_en4, g_en4;
  logic [1:0]  alu_op4;
  logic [3:0]  reg_sel4, reg_en4;
  logic [15:0] retired4;
  state_t      dbg_state4;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  seq_control_unit #(.NREGS(8)) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .instr(instr),
    .ready(ready), .done(done), .err(err), .alu_op(alu_op),
    .imm_sel(imm_sel), .g_sel(g_sel), .reg_sel(reg_sel), .reg_en(reg_en),
    .a_en(a_en), .g_en(g_en), .retired(retired), .dbg_state(dbg_state)
  );

  seq_control_unit #(.NREGS(4)) dut4 (
    .clk(clk), .reset(reset), .run(run4), .stall(stall), .instr(instr4),
    .ready(ready4), .done(done4), .err(err4), .alu_op(alu_op4),
    .imm_sel(imm_sel4), .g_sel(g_sel4), .reg_sel(reg_sel4), .reg_en(reg_en4),
    .a_en(a_en4), .g_en(g_en4), .retired(retired4), .dbg_state(dbg_state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mk8(input logic [2:0] op, input int rx, input int ry);
    return {op, 3'(rx), 3'(ry)};
  endfunction

  // Present one instruction for a single accept edge, then scramble instr.
  task automatic issue(input logic [8:0] i);
    run   = 1'b1;
    instr = i;
    tick();
    run   = 1'b0;
    instr = 9'($urandom_range(0, 511));
  endtask

  task automatic chk_retired(input string tag);
    chk(tag, 32'(retired), 32'(exp_q[$]));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; stall = 1'b0; instr = '0;
    run4 = 1'b0; instr4 = '0;
    exp_q.push_back(16'd0);
    repeat (2) tick();
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_enables", 32'({reg_en, a_en, g_en, done, err}), 32'd0);
    chk_retired("rst_retired");
    reset = 1'b0;
    tick();

    // ADD r3 <- r3 + r5
    issue(mk8(OP_ADD, 3, 5));
    chk("add_t1_state", 32'(dbg_state), 32'(S_T1));
    chk("add_t1_sel", 32'(reg_sel), 32'h08);
    chk("add_t1_aen", 32'({a_en, g_en, ready, done}), 32'b1000);
    chk("add_t1_regen", 32'(reg_en), 32'h00);
    tick();
    chk("add_t2_sel", 32'(reg_sel), 32'h20);
    chk("add_t2_gen", 32'({a_en, g_en}), 32'b01);
    chk("add_t2_alu", 32'(alu_op), 32'(ALU_ADD));
    tick();
    chk("add_t3_gsel", 32'(g_sel), 32'd1);
    chk("add_t3_regen", 32'(reg_en), 32'h08);
    chk("add_t3_done", 32'({done, err}), 32'b10);
    tick();
    exp_q.push_back(16'd1);
    chk_retired("add_retired");
    chk("add_idle_ready", 32'({ready, reg_sel}), 32'h100);

    // MVI r7, then MV r0 <- r7 with run held high throughout
    run = 1'b1;
    instr = mk8(OP_MVI, 7, 0);
    tick();
    chk("mvi_done", 32'(done), 32'd1);
    chk("mvi_imm", 32'(imm_sel), 32'd1);
    chk("mvi_regen", 32'(reg_en), 32'h80);
    instr = mk8(OP_MV, 0, 7);
    tick();
    exp_q.push_back(16'd2);
    chk("b2b_gap_ready", 32'({ready, done}), 32'b10);
    chk_retired("mvi_retired");
    tick();
    chk("mv_done", 32'(done), 32'd1);
    chk("mv_regen", 32'(reg_en), 32'h01);
    chk("mv_sel", 32'(reg_sel), 32'h80);
    run = 1'b0;
    tick();
    exp_q.push_back(16'd3);
    chk_retired("mv_retired");

    // Illegal opcodes 111 and 110
    issue(mk8(3'b111, 1, 2));
    chk("ill7_errdone", 32'({err, done}), 32'b11);
    chk("ill7_enables", 32'({reg_en, reg_sel, a_en, g_en, imm_sel, g_sel}), 32'd0);
    tick();
    chk_retired("ill7_retired");
    chk("ill7_ready", 32'({ready, err}), 32'b10);
    issue(mk8(3'b110, 0, 0));
    chk("ill6_errdone", 32'({err, done}), 32'b11);
    tick();
    chk_retired("ill6_retired");

    // SUB r1 <- r1 - r2 with 4 stalled cycles in T2
    issue(mk8(OP_SUB, 1, 2));
    chk("sub_t1_sel", 32'({reg_sel, a_en}), 32'({8'h02, 1'b1}));
    tick();
    stall = 1'b1;
    #1;
    chk("sub_stall_gen", 32'(g_en), 32'd0);
    chk("sub_stall_sel", 32'(reg_sel), 32'h04);
    chk("sub_stall_alu", 32'(alu_op), 32'(ALU_SUB));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sub_stall_hold", 32'({dbg_state, g_en, reg_sel}), 32'({S_T2, 1'b0, 8'h04}));
    end
    stall = 1'b0;
    #1;
    chk("sub_t2_gen", 32'({g_en, alu_op}), 32'({1'b1, ALU_SUB}));
    tick();
    chk("sub_t3", 32'({done, g_sel, reg_en}), 32'({2'b11, 8'h02}));
    tick();
    exp_q.push_back(16'd4);
    chk_retired("sub_retired");

    // Stall ignored in IDLE; stall in T1 suppresses done/reg_en; rx == ry
    stall = 1'b1;
    issue(mk8(OP_MV, 2, 2));
    chk("stall_idle_accept", 32'(dbg_state), 32'(S_T1));
    chk("stall_t1_quiet", 32'({done, reg_en}), 32'd0);
    chk("stall_t1_sel", 32'(reg_sel), 32'h04);
    tick();
    chk("stall_t1_hold", 32'({dbg_state, done}), 32'({S_T1, 1'b0}));
    stall = 1'b0;
    #1;
    chk("rxry_done", 32'({done, reg_en, reg_sel}), 32'({1'b1, 8'h04, 8'h04}));
    tick();
    exp_q.push_back(16'd5);
    chk_retired("rxry_retired");

    // Reset in T2 of AND aborts with no writes
    issue(mk8(OP_AND, 4, 6));
    tick();
    chk("and_t2", 32'({alu_op, reg_sel}), 32'({ALU_AND, 8'h40}));
    reset = 1'b1;
    tick();
    exp_q.push_back(16'd0);
    chk("abort_ready", 32'({ready, dbg_state}), 32'({1'b1, S_IDLE}));
    chk("abort_quiet", 32'({reg_en, done, err, g_en, a_en}), 32'd0);
    chk_retired("abort_retired");
    reset = 1'b0;
    tick();

    // Counter wrap: preset just below the top, then two MVs
    dut.retired_q = 16'hFFFE;
    issue(mk8(OP_MV, 1, 0));
    tick();
    exp_q.push_back(16'hFFFF);
    chk_retired("wrap_ffff");
    issue(mk8(OP_MV, 1, 0));
    tick();
    exp_q.push_back(16'h0000);
    chk_retired("wrap_0000");

    // NREGS=4 build: OR r2 <- r2 | r1
    run4 = 1'b1;
    instr4 = {OP_OR, 2'd2, 2'd1};
    tick();
    run4 = 1'b0;
    instr4 = 7'($urandom_range(0, 127));
    chk("n4_t1", 32'({reg_sel4, a_en4}), 32'({4'h4, 1'b1}));
    tick();
    chk("n4_t2", 32'({reg_sel4, g_en4, alu_op4}), 32'({4'h2, 1'b1, ALU_OR}));
    tick();
    chk("n4_t3", 32'({reg_en4, done4, err4}), 32'({4'h4, 2'b10}));
    tick();
    chk("n4_retired", 32'(retired4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
